// File: rtl/pia_input_cond.sv
// Input conditioner for the PIA: synchronises and debounces raw buttons and DIP
// switches, applies SOCD cleaning and optional auto-fire, and drives active-low buttons.
module pia_input_cond #(
  parameter int DEBOUNCE      = 50000,
  parameter int CNT_W         = 16,
  parameter int AUTOFIRE_HALF = 1250000,
  parameter int AF_W          = 21,
  parameter bit SOCD_CLEAN    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] btn_raw,
  input  logic [3:0] sw_raw,
  output logic [6:0] buttons,
  output logic [3:0] sw,
  output logic [6:0] press_evt,
  output logic       autofire_active
);

  localparam int NIN   = 11;
  localparam int FIRE  = 1;
  localparam int UP    = 3;
  localparam int DOWN  = 4;
  localparam int LEFT  = 5;
  localparam int RIGHT = 6;
  localparam int AF_EN = 10;

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AF_W-1:0]  AF_MAX  = AF_W'(AUTOFIRE_HALF - 1);
  localparam logic [AF_W-1:0]  AF_ONE  = AF_W'(1);

  logic [NIN-1:0]   raw_s;
  logic [NIN-1:0]   sync1_r;
  logic [NIN-1:0]   sync2_r;
  logic [NIN-1:0]   stable_r;
  logic [NIN-1:0]   stable_nxt_s;
  logic [CNT_W-1:0] cnt_r     [NIN];
  logic [CNT_W-1:0] cnt_nxt_s [NIN];

  logic             af_phase_r;
  logic             af_phase_nxt_s;
  logic [AF_W-1:0]  af_cnt_r;
  logic [AF_W-1:0]  af_cnt_nxt_s;
  logic             af_active_s;
  logic             af_active_r;

  logic             fire_s;
  logic [6:0]       pressed_s;
  logic [6:0]       cond_s;
  logic [6:0]       buttons_r;
  logic [6:0]       press_evt_r;
  logic [3:0]       sw_r;

  assign raw_s = {sw_raw, btn_raw};

  // Debounce next-state: a differing level must persist DEBOUNCE samples to be accepted.
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      stable_nxt_s[i] = stable_r[i];
      cnt_nxt_s[i]    = {CNT_W{1'b0}};
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == DB_MAX) begin
        stable_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Auto-fire: the first shot fires on the cycle the feature becomes active.
  always_comb begin
    af_active_s    = stable_nxt_s[AF_EN] & stable_nxt_s[FIRE];
    af_phase_nxt_s = 1'b0;
    af_cnt_nxt_s   = {AF_W{1'b0}};
    if (!af_active_s) begin
      af_phase_nxt_s = 1'b0;
      af_cnt_nxt_s   = {AF_W{1'b0}};
    end else if (!af_active_r) begin
      af_phase_nxt_s = 1'b1;
      af_cnt_nxt_s   = {AF_W{1'b0}};
    end else if (af_cnt_r == AF_MAX) begin
      af_phase_nxt_s = ~af_phase_r;
      af_cnt_nxt_s   = {AF_W{1'b0}};
    end else begin
      af_phase_nxt_s = af_phase_r;
      af_cnt_nxt_s   = af_cnt_r + AF_ONE;
    end
  end

  // Conditioning works on next-state values so outputs update on the acceptance edge.
  always_comb begin
    pressed_s = stable_nxt_s[6:0];
    fire_s    = af_active_s ? af_phase_nxt_s : stable_nxt_s[FIRE];
    cond_s    = pressed_s;
    cond_s[FIRE] = fire_s;
    if (SOCD_CLEAN && pressed_s[UP] && pressed_s[DOWN]) begin
      cond_s[UP]   = 1'b0;
      cond_s[DOWN] = 1'b0;
    end else begin
      cond_s[UP]   = pressed_s[UP];
      cond_s[DOWN] = pressed_s[DOWN];
    end
    if (SOCD_CLEAN && pressed_s[LEFT] && pressed_s[RIGHT]) begin
      cond_s[LEFT]  = 1'b0;
      cond_s[RIGHT] = 1'b0;
    end else begin
      cond_s[LEFT]  = pressed_s[LEFT];
      cond_s[RIGHT] = pressed_s[RIGHT];
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r     <= {NIN{1'b0}};
      sync2_r     <= {NIN{1'b0}};
      stable_r    <= {NIN{1'b0}};
      for (int i = 0; i < NIN; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      af_phase_r  <= 1'b0;
      af_cnt_r    <= {AF_W{1'b0}};
      af_active_r <= 1'b0;
      buttons_r   <= 7'h7F;
      sw_r        <= 4'h0;
      press_evt_r <= 7'h00;
    end else begin
      sync1_r     <= raw_s;
      sync2_r     <= sync1_r;
      stable_r    <= stable_nxt_s;
      for (int i = 0; i < NIN; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      af_phase_r  <= af_phase_nxt_s;
      af_cnt_r    <= af_cnt_nxt_s;
      af_active_r <= af_active_s;
      buttons_r   <= ~cond_s;
      sw_r        <= stable_nxt_s[10:7];
      press_evt_r <= stable_nxt_s[6:0] & ~stable_r[6:0];
    end
  end

  assign buttons         = buttons_r;
  assign sw              = sw_r;
  assign press_evt       = press_evt_r;
  assign autofire_active = af_active_r;

endmodule
